uart_tx_arbiter: RTL

//   Shares one x_uart_tx byte transmitter between P_N byte sources (rx echo, status, debug).

---
 rtl/uart_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and limits for the UART transmitter arbiter.
package uart_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  localparam int ARB_W_DEF = 8;
  localparam int ARB_N_MIN = 2;
  localparam int ARB_N_MAX = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping at N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0] kk;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    kk  = '0;
    for (int i = 0; i < N; i++) begin
      kk = {1'b0, ptr} + (IW+1)'(i);
      if (kk >= (IW+1)'(N)) kk = kk - (IW+1)'(N);
      if (!any && req[kk[IW-1:0]]) begin
        gnt[kk[IW-1:0]] = 1'b1;
        idx             = kk[IW-1:0];
        any             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART byte transmitter between P_N sources.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int P_N       = 4,
  parameter int P_TIMEOUT = 1024,
  parameter int P_W       = ARB_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [P_N-1:0]     i_req_valid,
  input  logic [P_N*P_W-1:0] i_req_data,
  input  logic [P_N-1:0]     i_req_last,
  output logic [P_N-1:0]     o_req_accept,
  output logic               o_tx_valid,
  output logic [P_W-1:0]     o_tx_data,
  input  logic               i_tx_accept,
  output logic [P_N-1:0]     o_grant,
  output logic               o_busy,
  output logic               o_timeout
);

  localparam int IW = $clog2(P_N);
  localparam int CW = $clog2(P_TIMEOUT) + 1;
  localparam logic [0:0] IDLE = ARB_IDLE;
  localparam logic [0:0] LOCK = ARB_LOCK;

  logic [0:0]    state_q;
  logic [P_N-1:0] grant_q;
  logic [IW-1:0] gidx_q;
  logic [IW-1:0] ptr_q;
  logic [CW-1:0] cnt_q;
  logic          timeout_q;

  logic [P_N-1:0] pick_oh;
  logic [IW-1:0]  pick_idx;
  logic           pick_any;
  logic           tx_valid;
  logic [P_W-1:0] tx_data;
  logic           tx_last;
  logic           xfer;
  logic [IW-1:0]  nxt_ptr;

  rr_pick #(.N(P_N), .IW(IW)) u_pick (
    .req (i_req_valid),
    .ptr (ptr_q),
    .gnt (pick_oh),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Grant is one-hot or zero, so an OR of masked lanes is the mux; zero grant gives idle outputs.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = '0;
    tx_last  = 1'b0;
    for (int k = 0; k < P_N; k++) begin
      if (grant_q[k]) begin
        tx_valid = tx_valid | i_req_valid[k];
        tx_data  = tx_data  | i_req_data[k*P_W +: P_W];
        tx_last  = tx_last  | i_req_last[k];
      end
    end
  end

  assign xfer    = tx_valid & i_tx_accept;
  assign nxt_ptr = (gidx_q == IW'(P_N-1)) ? '0 : gidx_q + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (pick_any) begin
            grant_q <= pick_oh;
            gidx_q  <= pick_idx;
            state_q <= LOCK;
          end
        end
        default: begin
          if (xfer && tx_last) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= nxt_ptr;
            cnt_q   <= '0;
          end else if (tx_valid) begin
            // Owner is presenting data; waiting on the transmitter never times out.
            cnt_q <= '0;
          end else if (cnt_q >= CW'(P_TIMEOUT-1)) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= nxt_ptr;
            cnt_q     <= '0;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign o_grant      = grant_q;
  assign o_busy       = (state_q == LOCK);
  assign o_timeout    = timeout_q;
  assign o_tx_valid   = tx_valid;
  assign o_tx_data    = tx_data;
  assign o_req_accept = grant_q & {P_N{i_tx_accept}};

endmodule
